// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared encodings and helpers for the data-RAM arbiter
package dmem_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam int DMEM_BYTES = 1024;
  localparam int ADDR_W     = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_t;

  // Byte count of an access; the illegal size reports 4 so the range check stays monotonic.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// rtl/dmem_load_ext.sv - size extraction and sign/zero extension of a RAM read word
module dmem_load_ext
  import dmem_arbiter_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  always_comb begin
    data = rdata;
    case (size)
      SIZE_BYTE: data = {{24{~uns & rdata[7]}}, rdata[7:0]};
      SIZE_HALF: data = {{16{~uns & rdata[15]}}, rdata[15:0]};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port request arbiter and sequencer in front of the data RAM
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int MEM_BYTES   = DMEM_BYTES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [1:0]             req_we_i,
  input  logic [1:0][1:0]        req_size_i,
  input  logic [1:0]             req_unsigned_i,
  input  logic [1:0][ADDR_W-1:0] req_addr_i,
  input  logic [1:0][31:0]       req_wdata_i,
  output logic [1:0]             rsp_valid_o,
  output logic [31:0]            rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic                   mem_we_o,
  output logic [1:0]             mem_size_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [31:0]            mem_wdata_o,
  input  logic [31:0]            mem_rdata_i,
  output logic                   busy_o
);

  state_t              state, state_next;
  logic                grant;
  logic                accept;
  logic                req_err;
  logic [ADDR_W:0]     end_addr;
  logic                last_grant;
  logic                owner_q, we_q, uns_q, err_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         ext_data;

  // On a tie the port that did not win last time is served; fixed mode always favours port 0.
  always_comb begin
    grant = 1'b0;
    if (req_valid_i == 2'b11) begin
      grant = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
    end else begin
      grant = req_valid_i[1];
    end
  end

  assign accept      = (state == IDLE) && (|req_valid_i);
  assign req_ready_o = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign end_addr = {1'b0, req_addr_i[grant]} + {{(ADDR_W-2){1'b0}}, size_bytes(req_size_i[grant])};
  assign req_err  = (req_size_i[grant] == SIZE_ILL) || (end_addr > (ADDR_W+1)'(MEM_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_o <= 2'b00;
    end else begin
      if (accept) begin
        last_grant <= grant;
        owner_q    <= grant;
        we_q       <= req_we_i[grant];
        uns_q      <= req_unsigned_i[grant];
        err_q      <= req_err;
        size_q     <= req_size_i[grant];
        addr_q     <= req_addr_i[grant];
        wdata_q    <= req_wdata_i[grant];
      end
      rsp_valid_o <= (state == ISSUE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  dmem_load_ext u_load_ext (
    .rdata (mem_rdata_i),
    .size  (size_q),
    .uns   (uns_q),
    .data  (ext_data)
  );

  // Address/size/data registers only change at accept, so they hold outside ISSUE by construction.
  assign mem_addr_o  = addr_q;
  assign mem_size_o  = size_q;
  assign mem_wdata_o = wdata_q;

  always_comb begin
    state_next  = state;
    mem_we_o    = 1'b0;
    rsp_rdata_o = 32'h0;
    rsp_err_o   = 1'b0;
    busy_o      = (state != IDLE);
    case (state)
      IDLE: begin
        if (|req_valid_i) state_next = ISSUE;
      end
      ISSUE: begin
        mem_we_o   = we_q & ~err_q;
        state_next = DATA;
      end
      DATA: begin
        rsp_err_o   = err_q;
        rsp_rdata_o = (we_q || err_q) ? 32'h0 : ext_data;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter with a byte RAM model
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       ready;
  logic [1:0]       req_we;
  logic [1:0][1:0]  req_size;
  logic [1:0]       req_uns;
  logic [1:0][9:0]  req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             mem_we;
  logic [1:0]       mem_size;
  logic [9:0]       mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic             busy;

  logic [1:0]       fp_ready;
  logic [1:0]       fp_rsp_valid;
  logic [31:0]      fp_rsp_rdata;
  logic             fp_rsp_err;
  logic             fp_mem_we;
  logic [1:0]       fp_mem_size;
  logic [9:0]       fp_mem_addr;
  logic [31:0]      fp_mem_wdata;
  logic             fp_busy;
  logic [31:0]      zero_word;

  logic [7:0]       ram [0:1023];
  logic             ram_clear;

  int n_checks = 0;
  int n_fail   = 0;
  int rsp1_cnt = 0;

  dmem_arbiter #(.ROUND_ROBIN(1), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .mem_we_o(mem_we), .mem_size_o(mem_size),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .busy_o(busy)
  );

  dmem_arbiter #(.ROUND_ROBIN(0), .MEM_BYTES(1024)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(fp_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .rsp_valid_o(fp_rsp_valid), .rsp_rdata_o(fp_rsp_rdata),
    .rsp_err_o(fp_rsp_err), .mem_we_o(fp_mem_we), .mem_size_o(fp_mem_size),
    .mem_addr_o(fp_mem_addr), .mem_wdata_o(fp_mem_wdata), .mem_rdata_i(zero_word),
    .busy_o(fp_busy)
  );

  assign zero_word = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte RAM with a registered read port.
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata[7:0];
      if (mem_size != SIZE_BYTE) ram[mem_addr + 10'd1] <= mem_wdata[15:8];
      if (mem_size == SIZE_WORD) begin
        ram[mem_addr + 10'd2] <= mem_wdata[23:16];
        ram[mem_addr + 10'd3] <= mem_wdata[31:24];
      end
    end
    mem_rdata <= {ram[mem_addr + 10'd3], ram[mem_addr + 10'd2],
                  ram[mem_addr + 10'd1], ram[mem_addr]};
  end

  always @(negedge clk) begin
    if (rsp_valid[1]) rsp1_cnt++;
    if (rsp_valid == 2'b11) begin
      n_fail++;
      $display("FAIL rsp_valid_both: got %b required one-hot or zero", rsp_valid);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          port;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input int port, input logic we, input logic [1:0] size,
                     input logic uns, input logic [9:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.port = port; v.we = we; v.size = size; v.uns = uns;
    v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vq.push_back(v);
  endtask

  task automatic set_req(input int p, input logic we, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wdata);
    req_we[p] = we; req_size[p] = size; req_uns[p] = uns;
    req_addr[p] = addr; req_wdata[p] = wdata;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    logic [1:0] onehot;
    onehot = (v.port == 1) ? 2'b10 : 2'b01;
    set_req(v.port, v.we, v.size, v.uns, v.addr, v.wdata);
    req_valid[v.port] = 1'b1;
    n = 0;
    @(negedge clk);
    while (ready[v.port] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({v.name, " ready"}, {30'h0, ready}, {30'h0, onehot});
    if (ready[v.port] !== 1'b1) begin
      req_valid[v.port] = 1'b0;
      return;
    end
    @(posedge clk); #1 req_valid[v.port] = 1'b0;
    @(negedge clk);
    check({v.name, " issue_we"}, {31'h0, mem_we}, {31'h0, v.we & ~v.exp_err});
    check({v.name, " issue_addr"}, {22'h0, mem_addr}, {22'h0, v.addr});
    check({v.name, " issue_rsp_quiet"}, {30'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    check({v.name, " rsp_valid"}, {30'h0, rsp_valid}, {30'h0, onehot});
    check({v.name, " rdata"}, rsp_rdata, v.exp_rdata);
    check({v.name, " err"}, {31'h0, rsp_err}, {31'h0, v.exp_err});
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish required finish before 300us");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; ram_clear = 1'b1;
    req_valid = '0; req_we = '0; req_size = '0; req_uns = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy", {31'h0, busy}, 32'h0);
    check("rst ready", {30'h0, ready}, 32'h0);
    check("rst rsp_valid", {30'h0, rsp_valid}, 32'h0);
    check("rst rdata", rsp_rdata, 32'h0);
    check("rst err", {31'h0, rsp_err}, 32'h0);
    check("rst mem_we", {31'h0, mem_we}, 32'h0);
    check("rst mem_addr", {22'h0, mem_addr}, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1; ram_clear = 1'b0;
    @(posedge clk); #1;

    add("st_w_010",   0, 1, SIZE_WORD, 0, 10'h010, 32'hDEADBEEF, 32'h0,        0);
    add("ld_w_010",   0, 0, SIZE_WORD, 0, 10'h010, 32'h0,        32'hDEADBEEF, 0);
    add("ld_b_013s",  0, 0, SIZE_BYTE, 0, 10'h013, 32'h0,        32'hFFFFFFDE, 0);
    add("ld_b_013u",  0, 0, SIZE_BYTE, 1, 10'h013, 32'h0,        32'h000000DE, 0);
    add("ld_h_011s",  0, 0, SIZE_HALF, 0, 10'h011, 32'h0,        32'hFFFFADBE, 0);
    add("ld_h_011u",  1, 0, SIZE_HALF, 1, 10'h011, 32'h0,        32'h0000ADBE, 0);
    add("st_h_020",   1, 1, SIZE_HALF, 0, 10'h020, 32'h12348001, 32'h0,        0);
    add("ld_h_020s",  0, 0, SIZE_HALF, 0, 10'h020, 32'h0,        32'hFFFF8001, 0);
    add("st_b_3ff",   1, 1, SIZE_BYTE, 0, 10'h3FF, 32'hAAAAAA7F, 32'h0,        0);
    add("ld_b_3ff",   0, 0, SIZE_BYTE, 0, 10'h3FF, 32'h0,        32'h0000007F, 0);
    add("st_w_3fe",   0, 1, SIZE_WORD, 0, 10'h3FE, 32'h11223344, 32'h0,        1);
    add("ld_w_3fc",   0, 0, SIZE_WORD, 0, 10'h3FC, 32'h0,        32'h7F000000, 0);
    add("ld_ill",     1, 0, SIZE_ILL,  0, 10'h000, 32'h0,        32'h0,        1);
    add("ld_w_3fd",   0, 0, SIZE_WORD, 0, 10'h3FD, 32'h0,        32'h0,        1);
    add("ld_h_3ff",   0, 0, SIZE_HALF, 1, 10'h3FF, 32'h0,        32'h0,        1);
    add("ld_w_011",   0, 0, SIZE_WORD, 0, 10'h011, 32'h0,        32'h00DEADBE, 0);

    foreach (vq[i]) run_vec(vq[i]);
    check("ram_3fe_untouched", {24'h0, ram[10'h3FE]}, 32'h0);
    check("ram_3ff_untouched", {24'h0, ram[10'h3FF]}, 32'h7F);

    // Reset during ISSUE of a port-1 load.
    set_req(1, 0, SIZE_WORD, 0, 10'h010, 32'h0);
    req_valid[1] = 1'b1;
    n = 0;
    @(negedge clk);
    while (ready[1] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("abort ready", {30'h0, ready}, 32'h2);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    check("abort busy_issue", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", {31'h0, busy}, 32'h0);
    check("abort mem_we", {31'h0, mem_we}, 32'h0);
    check("abort rsp_valid", {30'h0, rsp_valid}, 32'h0);
    check("abort mem_addr", {22'h0, mem_addr}, 32'h0);
    check("abort mem_size", {30'h0, mem_size}, 32'h0);
    check("abort mem_wdata", mem_wdata, 32'h0);
    check("abort err", {31'h0, rsp_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp1_cnt = 0;
    repeat (6) @(negedge clk);
    check("abort no_rsp1", rsp1_cnt, 32'h0);
    @(posedge clk); #1;

    // Both ports valid: round-robin alternates from port 0, fixed priority always port 0.
    set_req(0, 0, SIZE_WORD, 0, 10'h000, 32'h0);
    set_req(1, 0, SIZE_WORD, 0, 10'h004, 32'h0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (ready === 2'b00 && n < 10) begin @(negedge clk); n++; end
      check($sformatf("rr grant%0d", k), {30'h0, ready}, (k % 2 == 1) ? 32'h2 : 32'h1);
      check($sformatf("fp grant%0d", k), {30'h0, fp_ready}, 32'h1);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;

    // Port 1 withdraws while port 0 is being served.
    set_req(0, 0, SIZE_BYTE, 1, 10'h013, 32'h0);
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("drop p0_ready", {30'h0, ready}, 32'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1;
    rsp1_cnt = 0;
    @(negedge clk);
    check("drop busy_ready", {30'h0, ready}, 32'h0);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("drop p0_rsp", {30'h0, rsp_valid}, 32'h1);
    check("drop p0_rdata", rsp_rdata, 32'h000000DE);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop next_p0", {30'h0, ready}, 32'h1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("drop no_rsp1", rsp1_cnt, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the 1024-byte data RAM. Accepts load/store requests from two requesters (port 0: core LSU, port 1: debug/loader), grants one at a time, drives the RAM's `we/size/addr/wdata` port, absorbs its one-cycle registered read latency and returns size-extracted, sign/zero-extended load data. Sits between the pipeline MEM stage / debug bridge and `dmem`.

## Interface
- `ROUND_ROBIN`, 1: 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- `MEM_BYTES`, 1024: RAM size in bytes; address width is fixed at 10.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_i[p]` in 1 (p = 0, 1): request pending.
- `req_ready_o[p]` out 1: request accepted this cycle.
- `req_we_i[p]` in 1: 1 = store, 0 = load.
- `req_size_i[p]` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned_i[p]` in 1: zero-extend the load (LBU/LHU).
- `req_addr_i[p]` in 10: byte address.
- `req_wdata_i[p]` in 32: store data, LSB-aligned.
- `rsp_valid_o[p]` out 1: one-cycle response pulse. No backpressure.
- `rsp_rdata_o` out 32: extended load data; 0 for stores and errors.
- `rsp_err_o` out 1: request was out of range or illegal.
- `mem_we_o` out 1: RAM write enable.
- `mem_size_o` out 2: RAM access size.
- `mem_addr_o` out 10: RAM byte address.
- `mem_wdata_o` out 32: RAM write data.
- `mem_rdata_i` in 32: RAM registered read word (byte at `addr` in [7:0]).
- `busy_o` out 1: FSM not in IDLE.

## Operation
- FSM states are IDLE, ISSUE, DATA.
  - IDLE → ISSUE when any `req_valid_i` is high.
  - ISSUE → DATA unconditionally.
  - DATA → IDLE unconditionally.
- Grant:
  - Evaluated combinationally in IDLE only.
  - `req_ready_o[g]` = 1 for the granted port only. The other port's ready stays 0.
  - Accepted fields are latched into `owner`, `we`, `size`, `uns`, `addr` and `wdata` registers.
- Round-robin:
  - `last_grant` register, reset value 1, so port 0 wins the first tie.
  - On a tie the port ≠ `last_grant` wins.
  - `last_grant` updates on every accept.
- Range check at accept:
  - bytes = 1, 2 or 4 by size.
  - Error if `addr + bytes > MEM_BYTES` (11-bit sum), or if size = 11.
  - Errored requests still walk ISSUE/DATA, but `mem_we_o` stays 0 and the response has `rsp_err_o` = 1 and `rdata` = 0.
- ISSUE: drive the `mem_*` outputs from the latched registers. `mem_we_o` = `we` & !err. The RAM samples at the end of ISSUE.
- DATA:
  - `rsp_valid_o[owner]` = 1.
  - Loads: byte → `mem_rdata_i[7:0]`; half → `[15:0]`; word → `[31:0]`. Sign-extended unless `uns`.
  - Stores: `rsp_rdata_o` = 0.
- `mem_addr_o`, `mem_size_o` and `mem_wdata_o` hold their last values outside ISSUE. `mem_we_o` is 0 outside ISSUE.
- Misaligned in-range accesses are legal and passed through unchanged (RAM is little-endian, byte-granular).

## Timing
- Request accepted at edge N (IDLE, ready = 1).
- ISSUE during cycle N+1.
- `rsp_valid_o` during cycle N+2.
- Next accept possible in cycle N+3 (IDLE). Throughput is 1 transaction per 3 cycles.
- Requester must hold all `req_*` fields stable while valid and not ready. Deasserting valid before ready is allowed; nothing is latched.
- Reset values:
  - FSM = IDLE.
  - All `req_ready_o` and `rsp_valid_o` = 0.
  - `rsp_rdata_o` = 0, `rsp_err_o` = 0.
  - `mem_we_o` = 0, `mem_size_o` = 0, `mem_addr_o` = 0, `mem_wdata_o` = 0.
  - `busy_o` = 0, `last_grant` = 1.
- Reset asserted mid-transaction:
  - Immediate return to IDLE and `mem_we_o` drops asynchronously.
  - No response is ever issued for the aborted request.
  - A write in ISSUE is not guaranteed to land.
- Simultaneous valid on both ports: exactly one is granted. The loser keeps valid and is guaranteed the next grant when ROUND_ROBIN = 1.
- `rsp_valid_o` is registered, one cycle wide, never asserted on both ports at once.

## Structure
- Shared header `misiri_defs.vh` (include-guarded) holds:
  - SIZE_BYTE/HALF/WORD encodings.
  - State encodings IDLE = 2'd0, ISSUE = 2'd1, DATA = 2'd2.
  - DMEM_BYTES = 1024.
- Sub-module `dmem_load_ext`: combinational size/sign extraction. Inputs are `rdata` 32, `size` 2, `uns` 1; output is `data` 32. The core's uncached paths reuse it.

## Test plan
- Port 0 store word 0xDEADBEEF @0x010, then load word @0x010 → `rsp_valid_o[0]` pulses 2 cycles after each accept; load data = 0xDEADBEEF, err = 0.
- Load byte @0x013, signed → 0xFFFFFFDE. Unsigned → 0x000000DE. Load half @0x011 signed → 0xFFFFADBE.
- Both ports valid continuously, loads @0x000/0x004 → grants alternate 0, 1, 0, 1 starting with port 0. With ROUND_ROBIN = 0, port 0 is always granted.
- Store word @0x3FE → `rsp_err_o` = 1, `mem_we_o` never asserted, RAM bytes 0x3FE/0x3FF unchanged. Load byte @0x3FF → no error. Size = 11 → error.
- Assert `rst_n` = 0 during ISSUE of a port-1 load → `busy_o` = 0 and all outputs at reset values immediately; no `rsp_valid_o[1]` after release.
- Port 1 drops valid before being granted (port 0 busy) → nothing latched, no port-1 response, next accept goes to port 0.
